axis_up_fifo: RTL

Elastic buffer on the user-project-to-Axis-Switch stream, directly downstream of the user-project AXI-Stream output multiplexer. It accepts the muxed beat (data, sideband, strobe, keep, last, user) and re-issues it toward the Axis Switch through a small synchronous FIFO. `s_tready` is driven from a register, which breaks the combinational ready path that the multiplexer passes straight through to every user project. It also tracks packet framing and counts completed output packets for debug.

---
 rtl/axis_up_fifo.sv | 87 ++++++++
 1 files changed

// File: rtl/axis_up_fifo.sv
// Elastic buffer between the user-project AXI-Stream mux and the Axis Switch.
// Registered s_tready cuts the ready path back into the mux; also tracks packet framing.
module axis_up_fifo #(
    parameter int pUSER_PROJECT_SIDEBAND_WIDTH = 5,
    parameter int pDATA_WIDTH                  = 32,
    parameter int pDEPTH                       = 4
) (
    input  logic                                    axis_clk,
    input  logic                                    axis_rst,
    input  logic                                    s_tvalid,
    input  logic [pDATA_WIDTH-1:0]                  s_tdata,
    input  logic [pUSER_PROJECT_SIDEBAND_WIDTH-1:0] s_tupsb,
    input  logic [3:0]                              s_tstrb,
    input  logic [3:0]                              s_tkeep,
    input  logic                                    s_tlast,
    input  logic [1:0]                              s_tuser,
    output logic                                    s_tready,
    output logic                                    m_tvalid,
    output logic [pDATA_WIDTH-1:0]                  m_tdata,
    output logic [pUSER_PROJECT_SIDEBAND_WIDTH-1:0] m_tupsb,
    output logic [3:0]                              m_tstrb,
    output logic [3:0]                              m_tkeep,
    output logic                                    m_tlast,
    output logic [1:0]                              m_tuser,
    input  logic                                    m_tready,
    output logic [$clog2(pDEPTH):0]                 fifo_count,
    output logic                                    pkt_open,
    output logic [15:0]                             pkt_cnt
);

    localparam int AW = $clog2(pDEPTH);
    localparam int CW = AW + 1;
    localparam int EW = pDATA_WIDTH + pUSER_PROJECT_SIDEBAND_WIDTH + 11;

    logic [EW-1:0] mem [pDEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          push;
    logic          pop;

    assign push       = s_tvalid & s_tready;
    assign pop        = m_tvalid & m_tready;
    assign m_tvalid   = (count != '0);
    assign fifo_count = count;

    // Head fields come straight from storage, never from the s_* inputs.
    assign {m_tdata, m_tupsb, m_tstrb, m_tkeep, m_tlast, m_tuser} = mem[rptr];

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !push) begin
            count_next = count - CW'(1);
        end
    end

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            mem      <= '{default: '0};
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            s_tready <= 1'b0;
            pkt_open <= 1'b0;
            pkt_cnt  <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= {s_tdata, s_tupsb, s_tstrb, s_tkeep, s_tlast, s_tuser};
                wptr      <= wptr + AW'(1);
                pkt_open  <= ~s_tlast;
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
                if (m_tlast) begin
                    pkt_cnt <= pkt_cnt + 16'd1;
                end
            end
            count    <= count_next;
            // Looking at the next occupancy drops ready on the edge that fills the FIFO.
            s_tready <= (count_next < CW'(pDEPTH));
        end
    end

endmodule
